// File: rtl/dispatch_buffer.sv
// Two-wide in-order circular FIFO between decode/register-read and RS dispatch.
// Optional stall/high-water statistics are enabled with `define DISPATCH_BUF_STATS_EN.
module dispatch_buffer #(
    parameter int DATA_W = 83,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid_A,
    input  logic [DATA_W-1:0]        in_inst_A,
    input  logic                     errorA,
    input  logic                     in_valid_B,
    input  logic [DATA_W-1:0]        in_inst_B,
    input  logic                     errorB,
    output logic                     in_ready,
    output logic                     in_taken_A,
    output logic                     in_taken_B,
    output logic                     out_valid_A,
    output logic [DATA_W-1:0]        out_inst_A,
    output logic                     out_valid_B,
    output logic [DATA_W-1:0]        out_inst_B,
    input  logic                     out_accept_A,
    input  logic                     out_accept_B,
    output logic [$clog2(DEPTH):0]   count
`ifdef DISPATCH_BUF_STATS_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [$clog2(DEPTH):0]   high_water
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  head_p1;
    logic [PTR_W-1:0]  tail_p1;
    logic              take_A;
    logic              take_B;
    logic              deq_A;
    logic              deq_B;
    logic [CNT_W-1:0]  enq_n;
    logic [CNT_W-1:0]  deq_n;
    logic [CNT_W-1:0]  count_next;

    // Readiness looks only at registered occupancy so a write never depends
    // on a same-cycle dequeue.
    assign in_ready   = (count <= CNT_W'(DEPTH - 2));
    assign take_A     = in_ready & in_valid_A & ~errorA & ~flush & ~rst;
    assign take_B     = take_A & in_valid_B & ~errorB;
    assign in_taken_A = take_A;
    assign in_taken_B = take_B;

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    assign out_valid_A = (count >= CNT_W'(1));
    assign out_valid_B = (count >= CNT_W'(2));
    assign out_inst_A  = out_valid_A ? mem[head]    : '0;
    assign out_inst_B  = out_valid_B ? mem[head_p1] : '0;

    assign deq_A = out_accept_A & out_valid_A;
    assign deq_B = deq_A & out_accept_B & out_valid_B;

    assign enq_n      = CNT_W'(take_A) + CNT_W'(take_B);
    assign deq_n      = CNT_W'(deq_A) + CNT_W'(deq_B);
    assign count_next = count + enq_n - deq_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_n);
            tail  <= tail + PTR_W'(enq_n);
            count <= count_next;
        end
    end

    // Entry storage is intentionally left unreset; validity comes from count.
    always_ff @(posedge clk) begin
        if (take_A) mem[tail]    <= in_inst_A;
        if (take_B) mem[tail_p1] <= in_inst_B;
    end

`ifdef DISPATCH_BUF_STATS_EN
    logic [CNT_W-1:0] count_upd;
    assign count_upd = flush ? '0 : count_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            high_water   <= '0;
        end else begin
            if (in_valid_A && !in_ready && !flush && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (count_upd > high_water)
                high_water <= count_upd;
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_buffer.sv
// Self-checking bench for dispatch_buffer: vector table plus queue scoreboard.
// Build with +define+DISPATCH_BUF_STATS_EN to also check the statistics outputs.
module tb_dispatch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid_A, errorA, in_valid_B, errorB;
    logic [82:0] in_inst_A, in_inst_B;
    logic        in_ready, in_taken_A, in_taken_B;
    logic        out_valid_A, out_valid_B;
    logic [82:0] out_inst_A, out_inst_B;
    logic        out_accept_A, out_accept_B;
    logic [3:0]  count;
`ifdef DISPATCH_BUF_STATS_EN
    logic [31:0] stall_cycles;
    logic [3:0]  high_water;
`endif

    int checks   = 0;
    int failures = 0;

    logic [82:0] mq[$];
    int unsigned stall_m = 0;
    int          hw_m    = 0;
    logic        s_ta, s_tb;

    always #5 clk = ~clk;

    dispatch_buffer #(.DATA_W(83), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid_A(in_valid_A), .in_inst_A(in_inst_A), .errorA(errorA),
        .in_valid_B(in_valid_B), .in_inst_B(in_inst_B), .errorB(errorB),
        .in_ready(in_ready), .in_taken_A(in_taken_A), .in_taken_B(in_taken_B),
        .out_valid_A(out_valid_A), .out_inst_A(out_inst_A),
        .out_valid_B(out_valid_B), .out_inst_B(out_inst_B),
        .out_accept_A(out_accept_A), .out_accept_B(out_accept_B),
        .count(count)
`ifdef DISPATCH_BUF_STATS_EN
        , .stall_cycles(stall_cycles), .high_water(high_water)
`endif
    );

    typedef struct packed {
        logic       va, ea, vb, eb, aa, ab, fl;
        logic       ta, tb;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called one time unit after a rising edge; drives, checks, then crosses the next edge.
    task automatic step(input logic va, ea, vb, eb, aa, ab, fl,
                        input logic [82:0] ia, input logic [82:0] ib);
        logic rdy, ta, tb, da, db;
        logic [82:0] ea_exp, eb_exp;
        int n;
        in_valid_A = va; errorA = ea; in_valid_B = vb; errorB = eb;
        out_accept_A = aa; out_accept_B = ab; flush = fl;
        in_inst_A = ia; in_inst_B = ib;
        #1;
        n   = mq.size();
        rdy = ((8 - n) >= 2);
        ta  = rdy & va & ~ea & ~fl;
        tb  = ta & vb & ~eb;
        da  = aa & (n >= 1);
        db  = da & ab & (n >= 2);
        ea_exp = (n >= 1) ? mq[0] : '0;
        eb_exp = (n >= 2) ? mq[1] : '0;
        chk("count",       count,       n);
        chk("in_ready",    in_ready,    rdy);
        chk("in_taken_A",  in_taken_A,  ta);
        chk("in_taken_B",  in_taken_B,  tb);
        chk("out_valid_A", out_valid_A, (n >= 1));
        chk("out_valid_B", out_valid_B, (n >= 2));
        chk("out_inst_A",  out_inst_A,  ea_exp);
        chk("out_inst_B",  out_inst_B,  eb_exp);
        s_ta = in_taken_A;
        s_tb = in_taken_B;
        @(posedge clk);
        #1;
        if (fl) mq.delete();
        else begin
            if (da) void'(mq.pop_front());
            if (db) void'(mq.pop_front());
            if (ta) mq.push_back(ia);
            if (tb) mq.push_back(ib);
        end
        if (va && !rdy && !fl && stall_m != 32'hFFFF_FFFF) stall_m++;
        if (mq.size() > hw_m) hw_m = mq.size();
`ifdef DISPATCH_BUF_STATS_EN
        chk("stall_cycles", stall_cycles, stall_m);
        chk("high_water",   high_water,   hw_m);
`endif
    endtask

    function automatic logic [82:0] word(input logic [18:0] tag, input int k);
        return {tag, 32'(k), $urandom};
    endfunction

    initial begin
        rst = 1'b1; flush = 0;
        in_valid_A = 0; errorA = 0; in_valid_B = 0; errorB = 0;
        in_inst_A = '0; in_inst_B = '0; out_accept_A = 0; out_accept_B = 0;

        //            va ea vb eb aa ab fl  ta tb cnt
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 4'd0};
        tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1, 4'd2};
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 4'd2};
        tbl[3]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0, 4'd3};
        tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 4'd3};
        tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1, 4'd5};
        tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1, 4'd7};
        tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0, 4'd6};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0, 4'd6};
        tbl[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b1, 4'd6};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0, 4'd5};
        tbl[11] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0, 4'd0};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 4'd0};

        #2;
        chk("rst_count",     count,       0);
        chk("rst_in_ready",  in_ready,    1);
        chk("rst_valid_A",   out_valid_A, 0);
        chk("rst_valid_B",   out_valid_B, 0);
        chk("rst_inst_A",    out_inst_A,  0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].va, tbl[i].ea, tbl[i].vb, tbl[i].eb, tbl[i].aa, tbl[i].ab, tbl[i].fl,
                 word(19'h1, i), word(19'h2, i));
            chk($sformatf("tbl%0d_taken_A", i), s_ta,  tbl[i].ta);
            chk($sformatf("tbl%0d_taken_B", i), s_tb,  tbl[i].tb);
            chk($sformatf("tbl%0d_count", i),   count, tbl[i].cnt);
        end

        // Two-in/two-out streaming across several pointer wraps.
        step(1, 0, 1, 0, 0, 0, 0, word(19'h3, 0), word(19'h4, 0));
        for (int i = 1; i <= 20; i++) begin
            step(1, 0, 1, 0, 1, 1, 0, word(19'h3, i), word(19'h4, i));
            chk("stream_count", count, 2);
        end
        step(0, 0, 0, 0, 0, 1, 0, '0, '0);
        chk("accept_B_alone", count, 2);

        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0), word(19'h5, i), word(19'h6, i));

        // Asynchronous reset in the middle of a cycle.
        step(1, 0, 1, 0, 0, 0, 0, word(19'h7, 0), word(19'h7, 1));
        step(1, 0, 1, 0, 0, 0, 0, word(19'h7, 2), word(19'h7, 3));
        in_valid_A = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_count",   count,       0);
        chk("midrst_valid_A", out_valid_A, 0);
        chk("midrst_valid_B", out_valid_B, 0);
        chk("midrst_inst_A",  out_inst_A,  0);
        chk("midrst_ready",   in_ready,    1);
        chk("midrst_taken_A", in_taken_A,  0);
        mq.delete();
        stall_m = 0;
        hw_m    = 0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill to seven, then hold A valid for three stalled cycles.
        step(1, 0, 1, 0, 0, 0, 0, word(19'h8, 0), word(19'h8, 1));
        step(1, 0, 1, 0, 0, 0, 0, word(19'h8, 2), word(19'h8, 3));
        step(1, 0, 1, 0, 0, 0, 0, word(19'h8, 4), word(19'h8, 5));
        step(1, 0, 0, 0, 0, 0, 0, word(19'h8, 6), '0);
        chk("fill_count", count, 7);
        for (int i = 0; i < 3; i++)
            step(1, 0, 1, 0, 0, 0, 0, word(19'h9, i), word(19'h9, i + 8));
        chk("stall_hold_count", count, 7);
`ifdef DISPATCH_BUF_STATS_EN
        chk("stats_stall_3",  stall_cycles, 3);
        chk("stats_hw_7",     high_water,   7);
`endif
        step(0, 0, 0, 0, 0, 0, 1, '0, '0);
        chk("flush_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
